plb_master_burst_engine: RTL and testbench
==========================================

Name: plb_master_burst_engine

Overview:
PLB master transaction engine sitting directly upstream of the PLB driver's M_* inputs and downstream of its PLB_M* outputs. It accepts one read or write command (32-bit address, 1..BURST_MAX doublewords) and runs the PLB address phase. It handles rearbitration and timeout, counts data beats, and streams 64-bit read data out or write data in. It reports completion and error status per command.

Parameters:
BURST_MAX, 16, maximum beats per command (power of 2, 2..16)
M_PRIORITY, 2'b00, constant driven on M_priority
ADDR_TIMEOUT, 255, cycles to wait for PLB_MAddrAck before aborting

Ports:
sys_clk_pin  in  1  sole clock
sys_rst_pin  in  1  asynchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  engine idle, command accepted on valid&ready
cmd_rnw  in  1  1=read, 0=write
cmd_addr  in  [0:31]  doubleword-aligned start address
cmd_len  in  [0:4]  beats minus 1 (0 = single)
wdata  in  [0:63]  write beat
wdata_ready  out  1  beat consumed this cycle (= PLB_MWrDAck in WR_DATA)
rdata  out  [0:63]  read beat
rdata_valid  out  1  one-cycle pulse per beat, no backpressure
done  out  1  one-cycle pulse at command end
done_err  out  1  valid with done: MErr seen or timeout
M_request, M_RNW, M_busLock, M_abort, M_rdBurst, M_wrBurst  out  1 each  PLB master controls
M_ABus  out  [0:31];  M_BE  out  [0:7];  M_size  out  [0:3];  M_type  out  [0:2];  M_MSize  out  [0:1];  M_priority  out  [0:1];  M_wrDBus  out  [0:63]
M_compress, M_guarded, M_ordered, M_lockErr  out  1 each  tied 0
PLB_MAddrAck, PLB_MRearbitrate, PLB_MRdDAck, PLB_MWrDAck, PLB_MRdBTerm, PLB_MWrBTerm, PLB_MErr, PLB_MBusy  in  1 each
PLB_MRdDBus  in  [0:63];  PLB_MRdWdAddr  in  [0:3];  PLB_MSSize  in  [0:1]

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0 except cmd_ready=1. Counters cleared, error flag cleared, no done pulse.
- All outputs are registered except wdata_ready and M_wrDBus, which are combinational passthroughs.
- IDLE: cmd_ready=1. On cmd_valid, latch rnw/addr/len, beats_left=len+1, go REQ next cycle.
- REQ: M_request=1, M_ABus=addr, M_RNW=rnw, M_BE=8'hFF, M_MSize=2'b10, M_type=3'b000, M_priority=M_PRIORITY.
  - M_size=4'b0000 if len==0, else 4'b1011 (doubleword burst).
  - M_rdBurst/M_wrBurst=1 if len>0.
  - Timeout counter increments each REQ cycle.
  - PLB_MAddrAck -> drop M_request next cycle; go RD_DATA or WR_DATA.
  - PLB_MRearbitrate without AddrAck -> M_request low for exactly one cycle (state REARB), then back to REQ. Timeout counter is not reset.
  - Counter == ADDR_TIMEOUT -> set error, go DONE.
  - AddrAck and Rearbitrate in the same cycle: AddrAck wins.
- RD_DATA: each PLB_MRdDAck -> rdata=PLB_MRdDBus, rdata_valid=1 next cycle, beats_left-=1. M_rdBurst deasserts registered on the ack that leaves beats_left==1. PLB_MRdBTerm -> deassert M_rdBurst next cycle; keep accepting acks until beats_left==0. Last ack -> DONE.
- WR_DATA: M_wrDBus=wdata. wdata_ready=PLB_MWrDAck. M_wrBurst=1 while beats_left>1, 0 on the final beat. PLB_MWrBTerm -> M_wrBurst low from next cycle. Last ack -> DONE.
- Write sourcing rule: the source holds a complete burst before issuing cmd_valid. wdata must be stable and valid every cycle of WR_DATA; no stall is possible.
- PLB_MErr in REQ/RD_DATA/WR_DATA sets a sticky error flag. The transfer continues to completion.
- DONE: one cycle; done=1, done_err=flag; flag cleared; return to IDLE. cmd_ready is 0 during DONE, so back-to-back commands have a 1-cycle gap.
- Counters: beats_left is 5 bits and is never decremented below 0. An extra ack while IDLE is ignored and flagged by the bench assertion.
- Unused inputs (PLB_MBusy, PLB_MRdWdAddr, PLB_MSSize) are ignored.

Decomposition:
- Package plb_master_pkg: state enum (IDLE, REQ, REARB, RD_DATA, WR_DATA, DONE), M_size encodings (SZ_SINGLE=4'b0000, SZ_DW_BURST=4'b1011), MSIZE_64=2'b10, BE_ALL=8'hFF.
- One natural sub-module: plb_beat_counter (load/decrement/last flag).

Test Plan:
- Single read at 0x0000_1000, len=0, AddrAck at cycle 2, RdDAck data 0xDEADBEEF_CAFEF00D -> M_size=0, M_rdBurst never 1, one rdata_valid with that data, done=1, done_err=0.
- 8-beat write at 0x2000, len=7, WrDAck every cycle -> 8 wdata_ready pulses, M_wrBurst high for 7 ack cycles and low on the 8th, done 1 cycle after the last ack.
- 16-beat read with PLB_MRearbitrate on the first two request cycles -> M_request pattern 1,0,1,0,1..., then a normal burst of 16 rdata_valid pulses.
- No AddrAck for 255 cycles -> done=1, done_err=1, M_request low, cmd_ready=1 next cycle.
- PLB_MErr pulsed mid-way through a 4-beat read -> all 4 beats delivered, done_err=1; the next command completes with done_err=0.
- sys_rst_pin asserted mid-WR_DATA -> all M_* outputs 0 asynchronously, cmd_ready=1, no done pulse after release.

Source files
------------

// File: rtl/plb_master_pkg.sv
`default_nettype none
// ============================================================================
// plb_master_pkg - engine state encoding and fixed PLB field values
// Rev 1.0
// ============================================================================
package plb_master_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REQ     = 3'd1,
      REARB   = 3'd2,
      RD_DATA = 3'd3,
      WR_DATA = 3'd4,
      DONE    = 3'd5
   } state_t;

   localparam logic [0:3] SZ_SINGLE   = 4'b0000;
   localparam logic [0:3] SZ_DW_BURST = 4'b1011;
   localparam logic [0:1] MSIZE_64    = 2'b10;
   localparam logic [0:7] BE_ALL      = 8'hFF;

   // Oversized requests are trimmed so the beat count always fits the burst limit.
   function automatic logic [4:0] clamp_len(input logic [4:0] len, input logic [4:0] max_len);
      return (len > max_len) ? max_len : len;
   endfunction

endpackage
`default_nettype wire

// File: rtl/plb_beat_counter.sv
`default_nettype none
// ============================================================================
// plb_beat_counter - remaining-beat counter with last / next-to-last flags
// Rev 1.0
// ============================================================================
module plb_beat_counter (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_load,
   input  logic [4:0] i_load_val,
   input  logic       i_dec,
   output logic       o_last,
   output logic       o_two
);

   logic [4:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= 5'd0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != 5'd0)) begin
         r_count <= r_count - 5'd1;
      end
   end

   assign o_last = (r_count == 5'd1);
   assign o_two  = (r_count == 5'd2);

endmodule
`default_nettype wire

// File: rtl/plb_master_burst_engine.sv
`default_nettype none
// ============================================================================
// plb_master_burst_engine - single-command PLB master: address phase with
// rearbitration/timeout, then beat-counted read or write data phase.  Rev 1.0
// ============================================================================
module plb_master_burst_engine
   import plb_master_pkg::*;
#(
   parameter int         BURST_MAX    = 16,
   parameter logic [0:1] M_PRIORITY   = 2'b00,
   parameter int         ADDR_TIMEOUT = 255
) (
   input  logic        sys_clk_pin,
   input  logic        sys_rst_pin,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_rnw,
   input  logic [0:31] cmd_addr,
   input  logic [0:4]  cmd_len,
   input  logic [0:63] wdata,
   output logic        wdata_ready,
   output logic [0:63] rdata,
   output logic        rdata_valid,
   output logic        done,
   output logic        done_err,
   output logic        M_request,
   output logic        M_RNW,
   output logic        M_busLock,
   output logic        M_abort,
   output logic        M_rdBurst,
   output logic        M_wrBurst,
   output logic [0:31] M_ABus,
   output logic [0:7]  M_BE,
   output logic [0:3]  M_size,
   output logic [0:2]  M_type,
   output logic [0:1]  M_MSize,
   output logic [0:1]  M_priority,
   output logic [0:63] M_wrDBus,
   output logic        M_compress,
   output logic        M_guarded,
   output logic        M_ordered,
   output logic        M_lockErr,
   input  logic        PLB_MAddrAck,
   input  logic        PLB_MRearbitrate,
   input  logic        PLB_MRdDAck,
   input  logic        PLB_MWrDAck,
   input  logic        PLB_MRdBTerm,
   input  logic        PLB_MWrBTerm,
   input  logic        PLB_MErr,
   input  logic        PLB_MBusy,
   input  logic [0:63] PLB_MRdDBus,
   input  logic [0:3]  PLB_MRdWdAddr,
   input  logic [0:1]  PLB_MSSize
);

   localparam int         TO_W    = $clog2(ADDR_TIMEOUT + 1);
   localparam logic [4:0] MAX_LEN = 5'(BURST_MAX - 1);

   state_t          r_state, w_next;
   logic            r_rnw;
   logic [0:31]     r_addr;
   logic [4:0]      r_len;
   logic [TO_W-1:0] r_to_cnt;
   logic            r_err;

   logic        r_cmd_ready, r_rdata_valid, r_done, r_done_err;
   logic [0:63] r_rdata;
   logic        r_m_request, r_m_rnw, r_m_rd_burst, r_m_wr_burst;
   logic [0:31] r_m_abus;
   logic [0:7]  r_m_be;
   logic [0:3]  r_m_size;
   logic [0:1]  r_m_msize, r_m_priority;

   logic        w_accept, w_rd_ack, w_wr_ack, w_timeout, w_err_next;
   logic        w_last, w_two, w_in_req, w_burst, w_eff_rnw;
   logic [0:31] w_eff_addr;
   logic [4:0]  w_cmd_len, w_eff_len;
   logic        w_unused;

   assign w_cmd_len  = clamp_len(cmd_len, MAX_LEN);
   assign w_accept   = (r_state == IDLE) && cmd_valid;
   assign w_rd_ack   = (r_state == RD_DATA) && PLB_MRdDAck;
   assign w_wr_ack   = (r_state == WR_DATA) && PLB_MWrDAck;
   assign w_timeout  = (r_state == REQ) && !PLB_MAddrAck && (r_to_cnt == TO_W'(ADDR_TIMEOUT - 1));
   assign w_err_next = r_err || w_timeout ||
                       (PLB_MErr && ((r_state == REQ) || (r_state == RD_DATA) || (r_state == WR_DATA)));

   // Entering REQ straight from IDLE must present the command before it is latched.
   assign w_eff_rnw  = w_accept ? cmd_rnw   : r_rnw;
   assign w_eff_addr = w_accept ? cmd_addr  : r_addr;
   assign w_eff_len  = w_accept ? w_cmd_len : r_len;
   assign w_in_req   = (w_next == REQ);
   assign w_burst    = (w_eff_len != 5'd0);

   plb_beat_counter u_beats (
      .clk        (sys_clk_pin),
      .rst        (sys_rst_pin),
      .i_load     (w_accept),
      .i_load_val (w_cmd_len + 5'd1),
      .i_dec      (w_rd_ack || w_wr_ack),
      .o_last     (w_last),
      .o_two      (w_two)
   );

   always_ff @(posedge sys_clk_pin or posedge sys_rst_pin) begin
      if (sys_rst_pin) r_state <= IDLE;
      else             r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (cmd_valid) w_next = REQ;
         REQ: begin
            if (PLB_MAddrAck)          w_next = r_rnw ? RD_DATA : WR_DATA;
            else if (w_timeout)        w_next = DONE;
            else if (PLB_MRearbitrate) w_next = REARB;
         end
         REARB:   w_next = REQ;
         RD_DATA: if (PLB_MRdDAck && w_last) w_next = DONE;
         WR_DATA: if (PLB_MWrDAck && w_last) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk_pin or posedge sys_rst_pin) begin
      if (sys_rst_pin) begin
         r_rnw         <= 1'b0;
         r_addr        <= '0;
         r_len         <= '0;
         r_to_cnt      <= '0;
         r_err         <= 1'b0;
         r_cmd_ready   <= 1'b1;
         r_rdata       <= '0;
         r_rdata_valid <= 1'b0;
         r_done        <= 1'b0;
         r_done_err    <= 1'b0;
         r_m_request   <= 1'b0;
         r_m_rnw       <= 1'b0;
         r_m_rd_burst  <= 1'b0;
         r_m_wr_burst  <= 1'b0;
         r_m_abus      <= '0;
         r_m_be        <= '0;
         r_m_size      <= '0;
         r_m_msize     <= '0;
         r_m_priority  <= '0;
      end else begin
         if (w_accept) begin
            r_rnw    <= cmd_rnw;
            r_addr   <= cmd_addr;
            r_len    <= w_cmd_len;
            r_to_cnt <= '0;
         end else if (r_state == REQ) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
         end
         r_err         <= (r_state == DONE) ? 1'b0 : w_err_next;
         r_cmd_ready   <= (w_next == IDLE);
         r_done        <= (w_next == DONE);
         r_done_err    <= (w_next == DONE) && w_err_next;
         r_rdata_valid <= w_rd_ack;
         if (w_rd_ack) r_rdata <= PLB_MRdDBus;

         r_m_request  <= w_in_req;
         r_m_rnw      <= w_in_req && w_eff_rnw;
         r_m_abus     <= w_in_req ? w_eff_addr : '0;
         r_m_be       <= w_in_req ? BE_ALL : '0;
         r_m_msize    <= w_in_req ? MSIZE_64 : '0;
         r_m_priority <= w_in_req ? M_PRIORITY : '0;
         r_m_size     <= !w_in_req ? SZ_SINGLE : (w_burst ? SZ_DW_BURST : SZ_SINGLE);

         // Burst drops on the ack leaving one beat, on BTerm, or on leaving the data phase.
         if (w_in_req)
            r_m_rd_burst <= w_eff_rnw && w_burst;
         else if ((w_next != RD_DATA) || (w_rd_ack && w_two) || ((r_state == RD_DATA) && PLB_MRdBTerm))
            r_m_rd_burst <= 1'b0;

         if (w_in_req)
            r_m_wr_burst <= !w_eff_rnw && w_burst;
         else if ((w_next != WR_DATA) || (w_wr_ack && w_two) || ((r_state == WR_DATA) && PLB_MWrBTerm))
            r_m_wr_burst <= 1'b0;
      end
   end

   assign cmd_ready   = r_cmd_ready;
   assign rdata       = r_rdata;
   assign rdata_valid = r_rdata_valid;
   assign done        = r_done;
   assign done_err    = r_done_err;
   assign M_request   = r_m_request;
   assign M_RNW       = r_m_rnw;
   assign M_rdBurst   = r_m_rd_burst;
   assign M_wrBurst   = r_m_wr_burst;
   assign M_ABus      = r_m_abus;
   assign M_BE        = r_m_be;
   assign M_size      = r_m_size;
   assign M_MSize     = r_m_msize;
   assign M_priority  = r_m_priority;
   assign M_type      = 3'b000;
   assign M_busLock   = 1'b0;
   assign M_abort     = 1'b0;
   assign M_compress  = 1'b0;
   assign M_guarded   = 1'b0;
   assign M_ordered   = 1'b0;
   assign M_lockErr   = 1'b0;

   assign wdata_ready = w_wr_ack;
   assign M_wrDBus    = (r_state == WR_DATA) ? wdata : '0;

   assign w_unused = &{1'b0, PLB_MBusy, PLB_MRdWdAddr, PLB_MSSize};

endmodule
`default_nettype wire

// File: tb/tb_plb_master_burst_engine.sv
`default_nettype none
// ============================================================================
// tb_plb_master_burst_engine - directed + random commands against a PLB slave
// model; expectations derived from command length and injected events. Rev 1.0
// ============================================================================
module tb_plb_master_burst_engine;

   localparam int BURST_MAX    = 16;
   localparam int ADDR_TIMEOUT = 255;

   logic        sys_clk_pin = 1'b0;
   logic        sys_rst_pin = 1'b0;
   logic        cmd_valid = 1'b0, cmd_rnw = 1'b0;
   logic [0:31] cmd_addr = '0;
   logic [0:4]  cmd_len = '0;
   logic [0:63] wdata = '0;
   logic        cmd_ready, wdata_ready, rdata_valid, done, done_err;
   logic [0:63] rdata, M_wrDBus;
   logic        M_request, M_RNW, M_busLock, M_abort, M_rdBurst, M_wrBurst;
   logic [0:31] M_ABus;
   logic [0:7]  M_BE;
   logic [0:3]  M_size;
   logic [0:2]  M_type;
   logic [0:1]  M_MSize, M_priority;
   logic        M_compress, M_guarded, M_ordered, M_lockErr;
   logic        PLB_MAddrAck = 1'b0, PLB_MRearbitrate = 1'b0, PLB_MRdDAck = 1'b0;
   logic        PLB_MWrDAck = 1'b0, PLB_MRdBTerm = 1'b0, PLB_MWrBTerm = 1'b0;
   logic        PLB_MErr = 1'b0, PLB_MBusy = 1'b0;
   logic [0:63] PLB_MRdDBus = '0;
   logic [0:3]  PLB_MRdWdAddr = '0;
   logic [0:1]  PLB_MSSize = '0;

   int n_vec = 0;
   int n_err = 0;

   plb_master_burst_engine #(
      .BURST_MAX    (BURST_MAX),
      .M_PRIORITY   (2'b01),
      .ADDR_TIMEOUT (ADDR_TIMEOUT)
   ) dut (
      .sys_clk_pin(sys_clk_pin), .sys_rst_pin(sys_rst_pin),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wdata(wdata), .wdata_ready(wdata_ready),
      .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .done_err(done_err),
      .M_request(M_request), .M_RNW(M_RNW), .M_busLock(M_busLock), .M_abort(M_abort),
      .M_rdBurst(M_rdBurst), .M_wrBurst(M_wrBurst), .M_ABus(M_ABus), .M_BE(M_BE),
      .M_size(M_size), .M_type(M_type), .M_MSize(M_MSize), .M_priority(M_priority),
      .M_wrDBus(M_wrDBus), .M_compress(M_compress), .M_guarded(M_guarded),
      .M_ordered(M_ordered), .M_lockErr(M_lockErr),
      .PLB_MAddrAck(PLB_MAddrAck), .PLB_MRearbitrate(PLB_MRearbitrate),
      .PLB_MRdDAck(PLB_MRdDAck), .PLB_MWrDAck(PLB_MWrDAck), .PLB_MRdBTerm(PLB_MRdBTerm),
      .PLB_MWrBTerm(PLB_MWrBTerm), .PLB_MErr(PLB_MErr), .PLB_MBusy(PLB_MBusy),
      .PLB_MRdDBus(PLB_MRdDBus), .PLB_MRdWdAddr(PLB_MRdWdAddr), .PLB_MSSize(PLB_MSSize)
   );

   always #5 sys_clk_pin = ~sys_clk_pin;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge sys_clk_pin);
      #1;
   endtask

   // One complete command: bench plays the PLB slave and predicts every
   // observable from the command length and the events it injects.
   task automatic run_cmd(input bit rnw, input logic [31:0] addr, input int len,
                          input int n_rearb, input int ack_delay, input bit to,
                          input int gap_max, input int merr_beat, input int bterm_beat,
                          input logic [63:0] first_data);
      logic [63:0] beats[$];
      logic [63:0] d;
      int          n, g;
      bit          exp_burst;
      n = len + 1;
      for (int i = 0; i < n; i++) begin
         d = {$urandom, $urandom};
         if (i == 0 && first_data != 64'd0) d = first_data;
         beats.push_back(d);
      end

      chk("cmd_ready_idle", 64'(cmd_ready), 64'(1));
      cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = addr; cmd_len = 5'(len); wdata = beats[0];
      tick;
      cmd_valid = 1'b0; cmd_rnw = ~rnw; cmd_addr = $urandom; cmd_len = 5'($urandom);
      chk("cmd_ready_busy", 64'(cmd_ready), 64'(0));

      for (int i = 0; i < n_rearb; i++) begin
         chk("req_rearb", 64'(M_request), 64'(1));
         PLB_MRearbitrate = 1'b1;
         tick;
         PLB_MRearbitrate = 1'b0;
         chk("req_rearb_gap", 64'(M_request), 64'(0));
         tick;
      end

      if (to) begin
         for (int i = 0; i < ADDR_TIMEOUT; i++) begin
            chk("to_req", 64'(M_request), 64'(1));
            tick;
         end
         chk("to_done", 64'(done), 64'(1));
         chk("to_done_err", 64'(done_err), 64'(1));
         chk("to_req_low", 64'(M_request), 64'(0));
         tick;
         chk("to_ready", 64'(cmd_ready), 64'(1));
         chk("to_done_once", 64'(done), 64'(0));
         return;
      end

      for (int i = 0; i < ack_delay; i++) begin
         chk("req_wait", 64'(M_request), 64'(1));
         tick;
      end
      chk("req_ack", 64'(M_request), 64'(1));
      chk("abus", 64'(M_ABus), 64'(addr));
      chk("rnw", 64'(M_RNW), 64'(rnw));
      chk("be", 64'(M_BE), 64'(8'hFF));
      chk("size", 64'(M_size), (len == 0) ? 64'(0) : 64'(4'b1011));
      chk("msize", 64'(M_MSize), 64'(2'b10));
      chk("prio", 64'(M_priority), 64'(2'b01));
      chk("type", 64'(M_type), 64'(0));
      chk("req_rdburst", 64'(M_rdBurst), 64'(rnw && len > 0));
      chk("req_wrburst", 64'(M_wrBurst), 64'(!rnw && len > 0));
      PLB_MAddrAck = 1'b1;
      PLB_MRearbitrate = 1'($urandom_range(1, 0));
      tick;
      PLB_MAddrAck = 1'b0;
      PLB_MRearbitrate = 1'b0;
      chk("req_drop", 64'(M_request), 64'(0));

      for (int b = 0; b < n; b++) begin
         g = $urandom_range(gap_max, 0);
         exp_burst = (n - b > 1) && (bterm_beat < 0 || b <= bterm_beat);
         if (rnw) begin
            repeat (g) begin
               tick;
               chk("rd_idle_valid", 64'(rdata_valid), 64'(0));
            end
            PLB_MRdDAck = 1'b1; PLB_MRdDBus = beats[b];
            PLB_MErr = (b == merr_beat); PLB_MRdBTerm = (b == bterm_beat);
            chk("rd_burst", 64'(M_rdBurst), 64'(exp_burst));
            tick;
            PLB_MRdDAck = 1'b0; PLB_MErr = 1'b0; PLB_MRdBTerm = 1'b0;
            PLB_MRdDBus = {$urandom, $urandom};
            chk("rd_valid", 64'(rdata_valid), 64'(1));
            chk("rd_data", 64'(rdata), beats[b]);
         end else begin
            repeat (g) begin
               #1;
               chk("wr_idle_ready", 64'(wdata_ready), 64'(0));
               tick;
            end
            PLB_MWrDAck = 1'b1;
            PLB_MErr = (b == merr_beat); PLB_MWrBTerm = (b == bterm_beat);
            #1;
            chk("wr_ready", 64'(wdata_ready), 64'(1));
            chk("wr_dbus", 64'(M_wrDBus), beats[b]);
            chk("wr_burst", 64'(M_wrBurst), 64'(exp_burst));
            tick;
            PLB_MWrDAck = 1'b0; PLB_MErr = 1'b0; PLB_MWrBTerm = 1'b0;
            if (b + 1 < n) wdata = beats[b + 1];
         end
         chk("data_done", 64'(done), 64'(b == n - 1));
         if (b == n - 1) chk("done_err", 64'(done_err), 64'(merr_beat >= 0));
      end
      tick;
      chk("ready_after", 64'(cmd_ready), 64'(1));
      chk("done_once", 64'(done), 64'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int r_rnw_sel, r_len_sel, r_merr, r_bterm;

      #1 sys_rst_pin = 1'b1;
      #10;
      chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
      chk("rst_request", 64'(M_request), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_rdata_valid", 64'(rdata_valid), 64'(0));
      chk("rst_abus", 64'(M_ABus), 64'(0));
      chk("rst_be", 64'(M_BE), 64'(0));
      chk("rst_bursts", 64'({M_rdBurst, M_wrBurst}), 64'(0));
      chk("rst_wdata_ready", 64'(wdata_ready), 64'(0));
      @(negedge sys_clk_pin);
      sys_rst_pin = 1'b0;
      tick;

      // single read, AddrAck on the second request cycle
      run_cmd(1'b1, 32'h0000_1000, 0, 0, 1, 1'b0, 0, -1, -1, 64'hDEADBEEF_CAFEF00D);
      // 8-beat write acked every cycle
      run_cmd(1'b0, 32'h0000_2000, 7, 0, 0, 1'b0, 0, -1, -1, 64'd0);
      // 16-beat read after two rearbitrations
      run_cmd(1'b1, 32'h0000_3000, 15, 2, 0, 1'b0, 0, -1, -1, 64'd0);
      // address-phase timeout
      run_cmd(1'b1, 32'h0000_4000, 3, 0, 0, 1'b1, 0, -1, -1, 64'd0);
      // MErr mid-read, then a clean command
      run_cmd(1'b1, 32'h0000_5000, 3, 0, 1, 1'b0, 1, 2, -1, 64'd0);
      run_cmd(1'b0, 32'h0000_5100, 3, 0, 0, 1'b0, 1, -1, -1, 64'd0);
      // burst termination on read and write
      run_cmd(1'b1, 32'h0000_6000, 7, 0, 0, 1'b0, 1, -1, 2, 64'd0);
      run_cmd(1'b0, 32'h0000_6100, 5, 0, 0, 1'b0, 1, -1, 1, 64'd0);

      // stray data acks while idle must be ignored
      PLB_MRdDAck = 1'b1; PLB_MWrDAck = 1'b1; PLB_MRdDBus = {$urandom, $urandom};
      #1;
      chk("idle_wdata_ready", 64'(wdata_ready), 64'(0));
      tick;
      PLB_MRdDAck = 1'b0; PLB_MWrDAck = 1'b0;
      chk("idle_rdata_valid", 64'(rdata_valid), 64'(0));
      chk("idle_done", 64'(done), 64'(0));
      chk("idle_ready", 64'(cmd_ready), 64'(1));

      // asynchronous reset in the middle of a write burst
      cmd_valid = 1'b1; cmd_rnw = 1'b0; cmd_addr = 32'h0000_7000; cmd_len = 5'd7;
      wdata = 64'h1111_2222_3333_4444;
      tick;
      cmd_valid = 1'b0;
      chk("mrst_req", 64'(M_request), 64'(1));
      PLB_MAddrAck = 1'b1;
      tick;
      PLB_MAddrAck = 1'b0;
      PLB_MWrDAck = 1'b1;
      tick;
      #1;
      chk("mrst_wready_before", 64'(wdata_ready), 64'(1));
      chk("mrst_wrburst_before", 64'(M_wrBurst), 64'(1));
      sys_rst_pin = 1'b1;
      #1;
      chk("mrst_request", 64'(M_request), 64'(0));
      chk("mrst_wrburst", 64'(M_wrBurst), 64'(0));
      chk("mrst_wrdbus", 64'(M_wrDBus), 64'(0));
      chk("mrst_wdata_ready", 64'(wdata_ready), 64'(0));
      chk("mrst_abus", 64'(M_ABus), 64'(0));
      chk("mrst_cmd_ready", 64'(cmd_ready), 64'(1));
      PLB_MWrDAck = 1'b0;
      #4 sys_rst_pin = 1'b0;
      repeat (4) begin
         tick;
         chk("mrst_no_done", 64'(done), 64'(0));
      end
      chk("mrst_ready_after", 64'(cmd_ready), 64'(1));

      for (int k = 0; k < 20; k++) begin
         r_rnw_sel = $urandom_range(1, 0);
         r_len_sel = $urandom_range(BURST_MAX - 1, 0);
         r_merr    = ($urandom_range(3, 0) == 0) ? int'($urandom_range(r_len_sel, 0)) : -1;
         r_bterm   = ($urandom_range(3, 0) == 0) ? int'($urandom_range(r_len_sel, 0)) : -1;
         run_cmd(r_rnw_sel[0], $urandom & 32'hFFFF_FFF8, r_len_sel, $urandom_range(2, 0),
                 $urandom_range(3, 0), 1'b0, 2, r_merr, r_bterm, 64'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
